dff_reg_arbiter: RTL and testbench
==================================

Name: dff_reg_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit D-flip-flop storage register between NREQ requesters.
- Each requester raises req, waits for its one-hot gnt, then writes wdata into the shared register on every granted cycle until it releases the grant or its hold budget expires.
- Sits in front of the flip-flop register bank as its sequencing and ownership controller; downstream logic reads q, q_valid and owner.

Parameters:
- NREQ, 4, number of requesters (2..8).
- OWN_W, 2, width of owner index; must be at least ceil(log2(NREQ)).
- WIDTH, 8, storage register width.
- HOLD_MAX, 4, maximum consecutive granted cycles per tenure (1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- req  input  NREQ  per-requester request, level-sensitive.
- last  input  NREQ  per-requester "final write this cycle" strobe.
- wdata  input  NREQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, registered.
- owner  output  OWN_W  index of the current or most recent grantee, registered.
- q  output  WIDTH  shared register contents.
- q_valid  output  1  high once q has been written since reset.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, owner=0, q=0, q_valid=0, hold_cnt=0, rr_ptr=0 (next search starts at index 0).
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If any req=1, pick the first set req at or after rr_ptr, wrapping modulo NREQ.
  - Next edge: gnt[k]=1, owner=k, hold_cnt=1, state→GRANT.
  - Grant latency is exactly 1 cycle from req sampled high.
- GRANT, each edge with gnt[k]=1:
  - Write rule: if req[k]=1, then q←wdata[k] and q_valid←1.
  - If req[k]=0, q holds and tenure ends with no write.
  - Tenure ends when any of these holds: req[k]=0; req[k]&last[k]; hold_cnt==HOLD_MAX.
  - On end: gnt←0, rr_ptr←(k+1) mod NREQ, state→RELEASE.
  - Otherwise: hold_cnt←hold_cnt+1.
- RELEASE: exactly one idle cycle with gnt=0 (bus turnaround), then →IDLE. Arbitration resumes in IDLE, so the worst-case gap between grants is 2 cycles.
- Fairness: after requester k is served, k has lowest priority. A requester that is continuously requesting is granted within NREQ-1 other tenures.
- Simultaneous events: last[k] together with hold expiry is a single release. last from non-granted requesters is ignored. req changes on non-granted lines during GRANT do not affect the current tenure.
- Reset mid-tenure: gnt drops asynchronously, q clears, and no partial write is retained.
- gnt is never multi-hot, including during reset assertion and deassertion.
- owner holds its value through RELEASE and IDLE until the next grant.
- Arithmetic: hold_cnt is 4 bits and saturates by construction. rr_ptr increments modulo NREQ; non-power-of-2 NREQ wraps explicitly.

Optional Feature:
- Macro: DFF_REG_PARITY_EN.
- Defined:
  - Adds output q_par (1 bit) = even parity of q, registered in the same edge as q. Reset value 0.
  - Adds input wpar[NREQ]. On a write, if ^wdata[k] != wpar[k], the write is dropped (q holds) and the tenure ends as if last[k] were asserted.
- Undefined: no q_par or wpar ports; all writes accepted.

Decomposition:
- Shared package/header dff_reg_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2;
  - HOLD_CNT_W=4;
  - default NREQ/WIDTH values.
- One natural sub-module: rr_pick. It is combinational: inputs req and rr_ptr, outputs a one-hot pick and its index. Instantiated once; the register and FSM stay in the top.

Test Plan:
- Reset then single requester: req=4'b0010, wdata[1]=8'hA5, last[1] on 2nd granted cycle → gnt=4'b0010 1 cycle after req; q=8'hA5 and q_valid=1 after the first granted edge; gnt=0 after the 2nd edge; one RELEASE cycle.
- Round robin: req=4'b1111 held, last asserted on the 1st granted cycle each time → grant order 0,1,2,3,0, with a 2-cycle gap between grants.
- Hold expiry: HOLD_MAX=4, req[2]=1 held, last=0, wdata incrementing 1,2,3,4,5 → exactly 4 writes, q=8'h04, then requester 2 re-granted only after the other requesters have been served.
- Early drop: req[0] deasserts in its 2nd granted cycle → no write that cycle, q keeps the 1st value, rr_ptr=1.
- Async reset mid-tenure: pull rst_n low between edges while gnt=4'b0100 → gnt=0, q=0, q_valid=0 immediately, without waiting for clk; after release, first grant goes to index 0.
- DFF_REG_PARITY_EN: wdata=8'h03 with wpar=1 → write dropped, q unchanged, tenure ends. wdata=8'h07 with wpar=1 → q=8'h07, q_par=1.

Source files
------------

// File: rtl/dff_reg_arbiter_pkg.sv
// Shared definitions for the dff_reg_arbiter slice.
// These are the state encodings, the hold counter width and the default sizes.
package dff_reg_arbiter_pkg;

    localparam int HOLD_CNT_W = 4;
    localparam int DEF_NREQ   = 4;
    localparam int DEF_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    // Successor index modulo n; written out explicitly so non-power-of-2 counts wrap correctly.
    function automatic int wrap_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dff_reg_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Returns the first set request at or after rr_ptr, as a one-hot vector and as an index.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int OWN_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [OWN_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  pick,
    output logic [OWN_W-1:0] pick_idx
);

    logic [NREQ-1:0]  rotated;
    logic [OWN_W-1:0] offset;
    logic [OWN_W:0]   sum;

    // Rotating the request vector puts rr_ptr at bit 0, so the lowest set bit is the winner.
    assign rotated = NREQ'({req, req} >> rr_ptr);

    always_comb begin
        offset = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = OWN_W'(i);
            end
        end
    end

    always_comb begin
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= (OWN_W + 1)'(NREQ)) begin
            sum = sum - (OWN_W + 1)'(NREQ);
        end
        pick_idx = sum[OWN_W-1:0];
        pick     = (|req) ? (NREQ'(1) << pick_idx) : '0;
    end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin ownership controller in front of one shared WIDTH-bit storage register.
// Define DFF_REG_PARITY_EN to add per-write parity checking (wpar) and a q_par output.
module dff_reg_arbiter
    import dff_reg_arbiter_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int OWN_W    = 2,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HOLD_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       last,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [OWN_W-1:0]      owner,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid
`ifdef DFF_REG_PARITY_EN
    ,
    input  logic [NREQ-1:0]       wpar,
    output logic                  q_par
`endif
);

    arb_state_t state, state_next;

    logic [HOLD_CNT_W-1:0] hold_cnt, hold_next;
    logic [OWN_W-1:0]      rr_ptr, rr_next, owner_next, pick_idx;
    logic [NREQ-1:0]       gnt_next, pick;
    logic [WIDTH-1:0]      cur_data;
    logic                  cur_req, cur_last, hold_done, data_ok;
    logic                  tenure_end, do_write;

    rr_pick #(
        .NREQ (NREQ),
        .OWN_W(OWN_W)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .pick    (pick),
        .pick_idx(pick_idx)
    );

    // Everything about the tenure is judged against the lane of the current owner only.
    assign cur_req   = req[owner];
    assign cur_last  = last[owner];
    assign cur_data  = wdata[int'(owner) * WIDTH +: WIDTH];
    assign hold_done = (hold_cnt == HOLD_CNT_W'(HOLD_MAX));

`ifdef DFF_REG_PARITY_EN
    assign data_ok = ((^cur_data) == wpar[owner]);
`else
    assign data_ok = 1'b1;
`endif

    assign tenure_end = !cur_req || cur_last || hold_done || !data_ok;
    assign do_write   = (state == ST_GRANT) && cur_req && data_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (|req) state_next = ST_GRANT;
            ST_GRANT:   if (tenure_end) state_next = ST_RELEASE;
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; gnt is only ever loaded from a one-hot pick or cleared.
    always_comb begin
        gnt_next   = '0;
        owner_next = owner;
        hold_next  = hold_cnt;
        rr_next    = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    gnt_next   = pick;
                    owner_next = pick_idx;
                    hold_next  = HOLD_CNT_W'(1);
                end
            end
            ST_GRANT: begin
                if (tenure_end) begin
                    rr_next = OWN_W'(wrap_next(int'(owner), NREQ));
                end else begin
                    gnt_next  = gnt;
                    hold_next = hold_cnt + HOLD_CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            gnt      <= gnt_next;
            owner    <= owner_next;
            hold_cnt <= hold_next;
            rr_ptr   <= rr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (do_write) begin
            q       <= cur_data;
            q_valid <= 1'b1;
        end
    end

`ifdef DFF_REG_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_par <= 1'b0;
        end else if (do_write) begin
            q_par <= ^cur_data;
        end
    end
`endif

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Scoreboard bench for dff_reg_arbiter: a tenure-level model predicts each cycle's outputs,
// and a separate monitor compares them against the DUT.
module tb_dff_reg_arbiter;

    localparam int NREQ     = 4;
    localparam int OWN_W    = 2;
    localparam int WIDTH    = 8;
    localparam int HOLD_MAX = 4;

    typedef struct {
        logic [NREQ-1:0]  gnt;
        logic [OWN_W-1:0] owner;
        logic [WIDTH-1:0] q;
        logic             qv;
        logic             qpar;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       last = '0;
    logic [NREQ*WIDTH-1:0] wdata = '0;
    logic [NREQ-1:0]       gnt;
    logic [OWN_W-1:0]      owner;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
`ifdef DFF_REG_PARITY_EN
    logic [NREQ-1:0]       wpar = '0;
    logic                  q_par;
`endif

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    int               m_cur, m_held, m_next;
    bit               m_turn;
    logic [OWN_W-1:0] m_owner;
    logic [WIDTH-1:0] m_q;
    logic             m_qv, m_qpar;

    always #5 clk = ~clk;

    dff_reg_arbiter #(
        .NREQ    (NREQ),
        .OWN_W   (OWN_W),
        .WIDTH   (WIDTH),
        .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .last   (last),
        .wdata  (wdata),
        .gnt    (gnt),
        .owner  (owner),
        .q      (q),
        .q_valid(q_valid)
`ifdef DFF_REG_PARITY_EN
        ,
        .wpar   (wpar),
        .q_par  (q_par)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] parOf(input logic [NREQ*WIDTH-1:0] d);
        logic [NREQ-1:0] p;
        for (int i = 0; i < NREQ; i++) p[i] = ^d[i*WIDTH +: WIDTH];
        return p;
    endfunction

    function automatic logic [NREQ*WIDTH-1:0] laneData(input int k, input logic [WIDTH-1:0] v);
        logic [NREQ*WIDTH-1:0] d;
        d = '0;
        d[k*WIDTH +: WIDTH] = v;
        return d;
    endfunction

    task automatic modelReset();
        m_cur   = -1;
        m_held  = 0;
        m_next  = 0;
        m_turn  = 0;
        m_owner = '0;
        m_q     = '0;
        m_qv    = 1'b0;
        m_qpar  = 1'b0;
    endtask

    // One clock of the model: a tenure lasts until the owner drops req, signals last,
    // sends bad parity, or has used HOLD_MAX cycles; then one turnaround cycle, then arbitration.
    task automatic modelStep(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                             input logic [NREQ*WIDTH-1:0] d, input logic [NREQ-1:0] p);
        if (m_cur >= 0) begin
            int k;
            logic [WIDTH-1:0] lane;
            bit ok;
            k    = m_cur;
            lane = d[k*WIDTH +: WIDTH];
            ok   = 1;
`ifdef DFF_REG_PARITY_EN
            ok = ((^lane) == p[k]);
`endif
            m_held++;
            if (r[k] && ok) begin
                m_q    = lane;
                m_qv   = 1'b1;
                m_qpar = ^lane;
            end
            if (!r[k] || l[k] || !ok || m_held == HOLD_MAX) begin
                m_cur  = -1;
                m_turn = 1;
                m_next = (k + 1) % NREQ;
            end
        end else if (m_turn) begin
            m_turn = 0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                int c;
                c = (m_next + i) % NREQ;
                if (r[c]) begin
                    m_cur   = c;
                    m_owner = OWN_W'(c);
                    m_held  = 0;
                    break;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                                 input logic [NREQ*WIDTH-1:0] d, input logic [NREQ-1:0] p);
        exp_t e;
        @(posedge clk);
        #3;
        if (!rst_n) begin
            rst_n = 1'b1;
            modelReset();
        end
        req   = r;
        last  = l;
        wdata = d;
`ifdef DFF_REG_PARITY_EN
        wpar  = p;
`endif
        modelStep(r, l, d, p);
        e.gnt = '0;
        if (m_cur >= 0) e.gnt[m_cur] = 1'b1;
        e.owner = m_owner;
        e.q     = m_q;
        e.qv    = m_qv;
        e.qpar  = m_qpar;
        expq.push_back(e);
    endtask

    task automatic quiesce(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, '0);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #2;
        if (rst_n && expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput("gnt", 32'(gnt), 32'(e.gnt));
            checkOutput("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
            checkOutput("owner", 32'(owner), 32'(e.owner));
            checkOutput("q", 32'(q), 32'(e.q));
            checkOutput("q_valid", 32'(q_valid), 32'(e.qv));
`ifdef DFF_REG_PARITY_EN
            checkOutput("q_par", 32'(q_par), 32'(e.qpar));
`endif
        end
    end

    initial begin
        logic [NREQ*WIDTH-1:0] d;
        logic [NREQ-1:0]       r, l, p;
        bit                    done;
        int                    cnt;

        modelReset();
        #12;
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_owner", 32'(owner), 32'd0);
        checkOutput("reset_q", 32'(q), 32'd0);
        checkOutput("reset_q_valid", 32'(q_valid), 32'd0);

        $display("[TB] round robin, last on first granted cycle");
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            applyStimulus(4'b1111, 4'b1111, d, parOf(d));
        end
        quiesce(3);

        $display("[TB] single requester, last on second granted cycle");
        done = 0;
        for (int i = 0; i < 6; i++) begin
            d = laneData(1, 8'hA5);
            r = done ? 4'b0000 : 4'b0010;
            l = (m_cur == 1 && m_held >= 1) ? 4'b0010 : 4'b0000;
            applyStimulus(r, l, d, parOf(d));
            if (m_turn) done = 1;
        end
        quiesce(2);

        $display("[TB] hold expiry then fairness");
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            d = laneData(2, 8'(cnt));
            if (m_cur == 2) cnt++;
            r = (i < 6) ? 4'b0100 : 4'b1111;
            l = (i < 6) ? 4'b0000 : 4'b1011;
            applyStimulus(r, l, d, parOf(d));
        end
        quiesce(3);

        $display("[TB] early drop by requester 0");
        done = 0;
        for (int i = 0; i < 6; i++) begin
            d = laneData(0, 8'($urandom));
            if (m_cur == 0 && m_held >= 1) done = 1;
            r = done ? 4'b0000 : 4'b0001;
            applyStimulus(r, '0, d, parOf(d));
        end
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            applyStimulus(4'b0011, 4'b0011, d, parOf(d));
        end
        quiesce(3);

        $display("[TB] asynchronous reset mid-tenure");
        d = laneData(2, 8'h5C);
        applyStimulus(4'b0100, '0, d, parOf(d));
        applyStimulus(4'b0100, '0, d, parOf(d));
        #2;
        checkOutput("pre_reset_gnt", 32'(gnt), 32'h4);
        rst_n = 1'b0;
        expq.delete();
        #1;
        checkOutput("async_gnt", 32'(gnt), 32'd0);
        checkOutput("async_q", 32'(q), 32'd0);
        checkOutput("async_q_valid", 32'(q_valid), 32'd0);
`ifdef DFF_REG_PARITY_EN
        checkOutput("async_q_par", 32'(q_par), 32'd0);
`endif
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            applyStimulus(4'b1111, 4'b1111, d, parOf(d));
        end
        quiesce(3);

`ifdef DFF_REG_PARITY_EN
        $display("[TB] parity drop and accept");
        d = laneData(0, 8'h03);
        applyStimulus(4'b0001, '0, d, 4'b0001);
        applyStimulus(4'b0001, '0, d, 4'b0001);
        quiesce(2);
        d = laneData(0, 8'h07);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 4'b0001, d, 4'b0001);
        quiesce(3);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            d = {$urandom};
            r = 4'($urandom);
            l = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            p = parOf(d);
`ifdef DFF_REG_PARITY_EN
            if ($urandom_range(0, 7) == 0) p = p ^ 4'($urandom);
`endif
            applyStimulus(r, l, d, p);
        end

        @(posedge clk);
        #4;
        checkOutput("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
